instruction_loader: RTL
=======================

# instruction_loader

Write-side companion to the instruction ROM: receives a program as a byte stream over a valid/ready handshake and packs the bytes into little-endian 32-bit words. Each completed word is written through a single write port into instruction memory, at consecutive word addresses starting at 0. While a load is in progress the block asserts `busy`, which the top level uses to hold the CPU in reset. The block sits between a byte source (UART receiver or testbench) and the write port of the instruction RAM.

## Interface

Parameters:
- `SIZE`, 64, instruction memory depth in 32-bit words.
- `ADDR_W`, `$clog2(SIZE)`, word address width.

Ports:
- `clk`  input  1  clock; all state changes on its rising edge.
- `rst`  input  1  reset; synchronous and active-high.
- `start`  input  1  single-cycle request to begin a load; sampled only in IDLE.
- `len`  input  ADDR_W+1  number of words to load; sampled with `start`.
- `in_valid`  input  1  byte source has a byte on `in_data`.
- `in_data`  input  8  byte value.
- `in_ready`  output  1  loader accepts a byte this cycle.
- `mem_we`  output  1  instruction memory write strobe, one cycle per word.
- `mem_a`  output  ADDR_W  word write address.
- `mem_wd`  output  32  word write data.
- `busy`  output  1  load in progress; drives the CPU hold.
- `done`  output  1  single-cycle pulse when the last word is written.
- `err`  output  1  sticky flag: the last `start` carried an illegal `len`; cleared by the next accepted `start` or by `rst`.

## Operation

- FSM states: IDLE, LOAD, DONE.
- **IDLE**
  - `start`=1 with 1 ≤ `len` ≤ SIZE: latch `len`, clear the word index and byte counter, clear `err`, go to LOAD.
  - `start`=1 with `len`=0: do nothing; no writes and no `done`.
  - `start`=1 with `len` > SIZE: set `err`, stay in IDLE; no writes.
- **LOAD**
  - `in_ready`=1 throughout this state. A byte is accepted when `in_valid` && `in_ready`.
  - Byte k (0..3) of a word goes to bits [8k+7:8k], so the first byte received is the least-significant byte.
  - A 2-bit byte counter tracks position; it wraps 3→0 when a word completes.
  - On the accept that completes a word: register `mem_wd` = assembled word, `mem_a` = word index, `mem_we`=1 for the following cycle, then increment the word index.
  - If that word is word `len`-1, the state goes to DONE on the same edge.
- **DONE**
  - Lasts exactly one cycle; `done`=1 in that cycle.
  - `in_ready`=0.
  - Unconditional return to IDLE.
- `start` is ignored outside IDLE.
- `busy` = (state != IDLE).
- `mem_a` and `mem_wd` hold their last written values when `mem_we`=0.
- Word index width is ADDR_W+1 internally; `mem_a` is its low ADDR_W bits. It never exceeds SIZE-1 when `mem_we`=1.

## Timing

- Reset values: `in_ready`=0, `mem_we`=0, `mem_a`=0, `mem_wd`=0, `busy`=0, `done`=0, `err`=0; state IDLE.
- `start` asserted at edge e: `busy`=1 and `in_ready`=1 from cycle e+1.
- Byte accept latency: the 4th byte of a word accepted in cycle t gives `mem_we`=1 in cycle t+1, with `mem_a`/`mem_wd` valid in the same cycle.
- Back-to-back bytes allowed every cycle. While `mem_we`=1 for word n, the loader may accept byte 0 of word n+1 in the same cycle.
- Last word: `mem_we`=1 and `done`=1 in the same cycle t+1 (DONE). `busy`=1 in t+1 and 0 from t+2.
- Minimum load time for `len`=N with continuous valid: 4N accept cycles + 1 DONE cycle.
- `in_valid` gaps stall assembly with no loss; the partial word is retained.
- `rst` mid-load: next cycle is the reset state. The partial word is discarded; words already written stay in memory. No `done` is produced.
- No back-pressure on the memory side; the write port completes in one cycle.

## Test plan

- Reset → all outputs 0; hold `in_valid`=1 for 5 cycles → `in_ready` stays 0 and there are no writes.
- `start`, `len`=2; bytes 13,00,00,00,93,00,10,00 back-to-back → `mem_we` at a=0 with wd=0x00000013, then at a=1 with wd=0x00100093. `done` coincides with the second write; `busy` falls one cycle later.
- `start`, `len`=1; bytes with random `in_valid` gaps (including a gap after byte 3) → exactly one write of the correct word; `in_ready` stays 1 until DONE.
- `start` with `len`=SIZE+1 → `err`=1, `busy`=0, no writes. Then `start` with `len`=SIZE and 4·SIZE bytes → `err` clears, addresses run 0..SIZE-1, no wrap.
- `start` with `len`=0 → nothing happens. A second `start` pulsed during LOAD → ignored; word count unchanged.
- `len`=3 load, `rst` asserted after 6 bytes → exactly 1 write observed (a=0), no `done`, all outputs at reset values next cycle. A fresh load then succeeds starting from a=0.

Source files
------------

// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
//
// Receives a program as a byte stream over a valid/ready handshake and packs
// it into little-endian 32-bit words. The first byte of a word is its least
// significant byte. Each finished word goes out through a single write port at
// consecutive word addresses starting at 0. While a load runs, busy holds the
// CPU in reset.
//
// Parameters
//   SIZE    instruction memory depth in 32-bit words
//   ADDR_W  word address width
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     one-cycle load request, only honoured in IDLE
//   len       number of words to load, sampled with start (1..SIZE is legal)
//   in_valid  byte source presents in_data
//   in_data   byte value
//   in_ready  loader accepts a byte this cycle (LOAD state only)
//   mem_we    one-cycle write strobe per completed word
//   mem_a     word write address (holds its value when mem_we=0)
//   mem_wd    word write data    (holds its value when mem_we=0)
//   busy      load in progress
//   done      one-cycle pulse, coincides with the last word's write
//   err       sticky: the last start carried len > SIZE
// ---------------------------------------------------------------------------
module instruction_loader #(
    parameter int SIZE   = 64,
    parameter int ADDR_W = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] SIZE_W = (ADDR_W+1)'(SIZE);
    localparam logic [ADDR_W:0] ONE_W  = (ADDR_W+1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_W:0]       len_q, len_d;
    // One bit wider than mem_a so that len = SIZE is representable.
    logic [ADDR_W:0]       widx_q, widx_d;
    logic [1:0]            bcnt_q, bcnt_d;
    // Bytes 0..2 of the word being assembled; byte 3 is taken straight
    // from in_data on the completing accept.
    logic [2:0][7:0]       byte_q, byte_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_a_q, mem_a_d;
    logic [31:0]           mem_wd_q, mem_wd_d;
    logic                  err_q, err_d;

    logic start_ok;
    logic start_bad;
    logic accept;
    logic word_done;
    logic last_word;

    // Request qualification. len = 0 is neither ok nor bad: it is ignored.
    assign start_ok  = start && (len != '0) && (len <= SIZE_W);
    assign start_bad = start && (len > SIZE_W);

    assign accept    = in_valid && in_ready;
    assign word_done = accept && (bcnt_q == 2'd3);
    assign last_word = word_done && (widx_q == (len_q - ONE_W));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok)  state_d = S_LOAD;
            S_LOAD:  if (last_word) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs decoded from state
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready = (state_q == S_LOAD);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
    end

    // -----------------------------------------------------------------------
    // Datapath: length latch, byte packing, word index, write port, err
    // -----------------------------------------------------------------------
    always_comb begin
        len_d    = len_q;
        widx_d   = widx_q;
        bcnt_d   = bcnt_q;
        byte_d   = byte_q;
        mem_we_d = 1'b0;
        mem_a_d  = mem_a_q;
        mem_wd_d = mem_wd_q;
        err_d    = err_q;

        if (state_q == S_IDLE) begin
            if (start_ok) begin
                len_d  = len;
                widx_d = '0;
                bcnt_d = 2'd0;
                err_d  = 1'b0;
            end else if (start_bad) begin
                err_d  = 1'b1;
            end
        end

        if (accept) begin
            // Two-bit counter wraps 3 -> 0 on the completing byte.
            bcnt_d = bcnt_q + 2'd1;
            if (word_done) begin
                mem_we_d = 1'b1;
                mem_a_d  = widx_q[ADDR_W-1:0];
                mem_wd_d = {in_data, byte_q[2], byte_q[1], byte_q[0]};
                widx_d   = widx_q + ONE_W;
            end else begin
                byte_d[bcnt_q] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            widx_q   <= '0;
            bcnt_q   <= 2'd0;
            byte_q   <= '0;
            mem_we_q <= 1'b0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
            err_q    <= 1'b0;
        end else begin
            len_q    <= len_d;
            widx_q   <= widx_d;
            bcnt_q   <= bcnt_d;
            byte_q   <= byte_d;
            mem_we_q <= mem_we_d;
            mem_a_q  <= mem_a_d;
            mem_wd_q <= mem_wd_d;
            err_q    <= err_d;
        end
    end

    assign mem_we = mem_we_q;
    assign mem_a  = mem_a_q;
    assign mem_wd = mem_wd_q;
    assign err    = err_q;

endmodule
